shared_mem_arbiter: RTL and testbench

Memory-side responder for the multi-core processor. It accepts concurrent read/write requests from all cores, serialises them onto one single-port RAM bank with round-robin arbitration, and returns read data plus a one-cycle acknowledge to each core. It replaces the per-core fan-in glue in front of the RAM: cores act as initiators, and this block is the responding end of the same bus.

---
 rtl/shared_mem_arbiter_pkg.sv | 19 +
 rtl/shared_mem_arbiter_mem_bank.sv | 34 +++
 rtl/shared_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the multi-core memory responder: FSM states,
// default geometry and the round-robin index helper.
package mem_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      RESP = 1'b1
   } arb_state_e;

   localparam int DEF_NO_OF_CORES = 2;
   localparam int DEF_DATA_LEN    = 16;
   localparam int DEF_ADDRESS_LEN = 8;
   localparam int DEF_MEM_DEPTH   = 256;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/shared_mem_arbiter_mem_bank.sv
// Single-port synchronous RAM bank: read-before-write, registered read data,
// contents are never reset.
module mem_bank
   import mem_arb_pkg::*;
#(
   parameter int DATA_LEN    = DEF_DATA_LEN,
   parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [ADDRESS_LEN-1:0] addr,
   input  logic [DATA_LEN-1:0]    wdata,
   output logic [DATA_LEN-1:0]    rdata
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [DATA_LEN-1:0] mem_q [MEM_DEPTH];
   logic [DATA_LEN-1:0] rdata_q;
   logic [IDX_W-1:0]    idx;

   assign idx = addr[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin responder serialising per-core read/write requests onto one RAM bank.
// Optional read coalescing is enabled by defining MEM_ARB_COALESCE_EN.
module shared_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NO_OF_CORES = DEF_NO_OF_CORES,
   parameter int DATA_LEN    = DEF_DATA_LEN,
   parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NO_OF_CORES-1:0]          req_read,
   input  logic [NO_OF_CORES-1:0]          req_write,
   input  logic [ADDRESS_LEN*NO_OF_CORES-1:0] req_addr,
   input  logic [DATA_LEN*NO_OF_CORES-1:0] req_wdata,
   output logic [DATA_LEN*NO_OF_CORES-1:0] rsp_rdata,
   output logic [NO_OF_CORES-1:0]          rsp_ack,
   output logic                            busy
);

   localparam int GW = (NO_OF_CORES > 1) ? $clog2(NO_OF_CORES) : 1;

   arb_state_e             state_q, state_d;
   logic [GW-1:0]          last_grant_q, last_grant_d;
   logic [NO_OF_CORES-1:0] ack_q, ack_d;
   logic [NO_OF_CORES-1:0] rd_sel_q, rd_sel_d;
   logic                   oor_q, oor_d;

   logic [ADDRESS_LEN-1:0] addr_c  [NO_OF_CORES];
   logic [DATA_LEN-1:0]    wdata_c [NO_OF_CORES];
   logic [NO_OF_CORES-1:0] req_vec;
   logic                   req_any;
   logic [GW-1:0]          win_idx;
   logic [NO_OF_CORES-1:0] win_onehot;
   logic [NO_OF_CORES-1:0] grant_mask;
   logic [ADDRESS_LEN-1:0] win_addr;
   logic [DATA_LEN-1:0]    win_wdata;
   logic                   win_is_wr;
   logic                   win_oor;
   logic                   mem_we;
   logic [DATA_LEN-1:0]    mem_rdata;
   logic [DATA_LEN-1:0]    rd_word;

   assign req_vec = req_read | req_write;
   assign req_any = |req_vec;

   // Search starts one past the previous winner so every core gets a turn.
   always_comb begin : pick
      int   idx;
      logic found;
      win_idx = '0;
      found   = 1'b0;
      idx     = rr_next(int'(last_grant_q), NO_OF_CORES);
      for (int k = 0; k < NO_OF_CORES; k++) begin
         if (!found && req_vec[GW'(idx)]) begin
            win_idx = GW'(idx);
            found   = 1'b1;
         end
         idx = rr_next(idx, NO_OF_CORES);
      end
   end

   always_comb begin
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   assign win_addr  = addr_c[win_idx];
   assign win_wdata = wdata_c[win_idx];
   assign win_is_wr = req_write[win_idx];

   if (MEM_DEPTH < 2**ADDRESS_LEN) begin : g_oor
      assign win_oor = (win_addr >= ADDRESS_LEN'(MEM_DEPTH));
   end else begin : g_no_oor
      assign win_oor = 1'b0;
   end

`ifdef MEM_ARB_COALESCE_EN
   logic [NO_OF_CORES-1:0] rd_match_c;

   for (genvar g = 0; g < NO_OF_CORES; g++) begin : g_match
      assign rd_match_c[g] = req_read[g] && !req_write[g] && (addr_c[g] == win_addr);
   end

   // Pure readers of the winning address share the winner's read beat.
   assign grant_mask = win_is_wr ? win_onehot : (win_onehot | rd_match_c);
`else
   assign grant_mask = win_onehot;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARB;
         last_grant_q <= GW'(NO_OF_CORES - 1);
         ack_q        <= '0;
         rd_sel_q     <= '0;
         oor_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         rd_sel_q     <= rd_sel_d;
         oor_q        <= oor_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      rd_sel_d     = '0;
      oor_d        = oor_q;
      mem_we       = 1'b0;
      unique case (state_q)
         ARB: begin
            if (req_any) begin
               state_d      = RESP;
               last_grant_d = win_idx;
               oor_d        = win_oor;
               mem_we       = win_is_wr && !win_oor;
               ack_d        = grant_mask;
               rd_sel_d     = win_is_wr ? '0 : grant_mask;
            end
         end
         RESP: begin
            state_d = ARB;
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   mem_bank #(
      .DATA_LEN    (DATA_LEN),
      .ADDRESS_LEN (ADDRESS_LEN),
      .MEM_DEPTH   (MEM_DEPTH)
   ) u_bank (
      .clk   (clk),
      .we    (mem_we),
      .addr  (win_addr),
      .wdata (win_wdata),
      .rdata (mem_rdata)
   );

   // The RAM output register is the response data during RESP; each core's
   // hold register keeps it afterwards until that core's next read.
   assign rd_word = oor_q ? '0 : mem_rdata;

   for (genvar g = 0; g < NO_OF_CORES; g++) begin : g_core
      logic [DATA_LEN-1:0] hold_q, hold_d;

      assign addr_c[g]  = req_addr[ADDRESS_LEN*g +: ADDRESS_LEN];
      assign wdata_c[g] = req_wdata[DATA_LEN*g +: DATA_LEN];
      assign hold_d     = rd_sel_q[g] ? rd_word : hold_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            hold_q <= '0;
         end else begin
            hold_q <= hold_d;
         end
      end

      assign rsp_rdata[DATA_LEN*g +: DATA_LEN] = rd_sel_q[g] ? rd_word : hold_q;
   end

   assign rsp_ack = ack_q;
   assign busy    = (state_q == RESP);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed cases with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_shared_mem_arbiter;

   localparam int N     = 2;
   localparam int DL    = 16;
   localparam int AL    = 8;
   localparam int DEPTH = 128;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_read, req_write, rsp_ack;
   logic [AL*N-1:0] req_addr;
   logic [DL*N-1:0] req_wdata, rsp_rdata;
   logic            busy;

   shared_mem_arbiter #(
      .NO_OF_CORES (N),
      .DATA_LEN    (DL),
      .ADDRESS_LEN (AL),
      .MEM_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_read  (req_read),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_rdata (rsp_rdata),
      .rsp_ack   (rsp_ack),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level model: memory image, pointer, and what each output must show.
   logic [DL-1:0] m_mem   [DEPTH];
   bit            m_known [DEPTH];
   int            m_last;
   bit            m_busy;
   logic [N-1:0]  m_ack;
   logic [DL-1:0] m_rd    [N];
   bit            m_rd_ok [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last = N - 1;
      m_busy = 1'b0;
      m_ack  = '0;
      for (int c = 0; c < N; c++) begin
         m_rd[c]    = '0;
         m_rd_ok[c] = 1'b1;
      end
   endtask

   task automatic model_edge(input logic [N-1:0] rd, input logic [N-1:0] wr,
                             input logic [AL*N-1:0] ap, input logic [DL*N-1:0] dp);
      int            w;
      int            a;
      logic [DL-1:0] v;
      bit            ok;
      if (m_busy) begin
         m_busy = 1'b0;
         m_ack  = '0;
         return;
      end
      if ((rd | wr) == '0) return;
      w = -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (w < 0 && (rd[c] || wr[c])) w = c;
      end
      m_last   = w;
      m_busy   = 1'b1;
      m_ack    = '0;
      m_ack[w] = 1'b1;
      a = int'(ap[AL*w +: AL]);
      if (wr[w]) begin
         if (a < DEPTH) begin
            m_mem[a]   = dp[DL*w +: DL];
            m_known[a] = 1'b1;
         end
      end else begin
         v  = (a < DEPTH) ? m_mem[a] : '0;
         ok = (a >= DEPTH) || m_known[a];
         m_rd[w]    = v;
         m_rd_ok[w] = ok;
`ifdef MEM_ARB_COALESCE_EN
         for (int c = 0; c < N; c++) begin
            if (c != w && rd[c] && !wr[c] && int'(ap[AL*c +: AL]) == a) begin
               m_ack[c]   = 1'b1;
               m_rd[c]    = v;
               m_rd_ok[c] = ok;
            end
         end
`endif
      end
   endtask

   task automatic compare_all();
      chk("ack", 32'(rsp_ack), 32'(m_ack));
      chk("busy", 32'(busy), 32'(m_busy));
      for (int c = 0; c < N; c++) begin
         if (m_rd_ok[c]) chk($sformatf("rdata%0d", c), 32'(rsp_rdata[DL*c +: DL]), 32'(m_rd[c]));
      end
   endtask

   // Drive one cycle's inputs at the falling edge, advance the model across the
   // rising edge, then check the DUT at the next falling edge.
   task automatic step(input bit rst, input logic [N-1:0] rd, input logic [N-1:0] wr,
                       input logic [AL-1:0] a0, input logic [AL-1:0] a1,
                       input logic [DL-1:0] d0, input logic [DL-1:0] d1);
      reset     = rst;
      req_read  = rd;
      req_write = wr;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
      if (rst) model_reset();
      else model_edge(rd, wr, {a1, a0}, {d1, d0});
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 16'd0, 16'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not end, expected end before 500us");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0]  rd, wr;
      logic [AL-1:0] ad [N];
      logic [DL-1:0] wd [N];
      bit            pend [N];

      reset     = 1'b1;
      req_read  = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(rsp_ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rdata", 32'(rsp_rdata), 32'h0);

      // Core 0 writes then reads back address 5.
      step(1'b0, 2'b00, 2'b01, 8'd5, 8'd0, 16'h00A5, 16'h0);
      chk("wr5_ack", 32'(rsp_ack), 32'h1);
      chk("wr5_busy", 32'(busy), 32'h1);
      idle();
      chk("wr5_ack_gone", 32'(rsp_ack), 32'h0);
      step(1'b0, 2'b01, 2'b00, 8'd5, 8'd0, 16'h0, 16'h0);
      chk("rd5_ack", 32'(rsp_ack), 32'h1);
      chk("rd5_data0", 32'(rsp_rdata[15:0]), 32'h00A5);
      chk("rd5_data1", 32'(rsp_rdata[31:16]), 32'h0);
      idle();

      // Preload 3 and 7, leaving core 1 as the last winner.
      step(1'b0, 2'b00, 2'b01, 8'd3, 8'd0, 16'h0333, 16'h0);
      idle();
      step(1'b0, 2'b00, 2'b10, 8'd0, 8'd7, 16'h0, 16'h0777);
      idle();

      // Simultaneous reads: core 0 in cycle 1, core 1 in cycle 3.
      step(1'b0, 2'b11, 2'b00, 8'd3, 8'd7, 16'h0, 16'h0);
      chk("dual_c1_ack", 32'(rsp_ack), 32'h1);
      chk("dual_c1_data0", 32'(rsp_rdata[15:0]), 32'h0333);
      step(1'b0, 2'b10, 2'b00, 8'd0, 8'd7, 16'h0, 16'h0);
      chk("dual_c2_ack", 32'(rsp_ack), 32'h0);
      step(1'b0, 2'b10, 2'b00, 8'd0, 8'd7, 16'h0, 16'h0);
      chk("dual_c3_ack", 32'(rsp_ack), 32'h2);
      chk("dual_c3_data1", 32'(rsp_rdata[31:16]), 32'h0777);
      chk("dual_c3_data0", 32'(rsp_rdata[15:0]), 32'h0333);
      idle();

      // Both cores read address 5 in the same cycle.
      step(1'b0, 2'b11, 2'b00, 8'd5, 8'd5, 16'h0, 16'h0);
`ifdef MEM_ARB_COALESCE_EN
      chk("same5_ack", 32'(rsp_ack), 32'h3);
      chk("same5_data0", 32'(rsp_rdata[15:0]), 32'h00A5);
      chk("same5_data1", 32'(rsp_rdata[31:16]), 32'h00A5);
      idle();
`else
      chk("same5_ack0", 32'(rsp_ack), 32'h1);
      chk("same5_data0", 32'(rsp_rdata[15:0]), 32'h00A5);
      step(1'b0, 2'b10, 2'b00, 8'd0, 8'd5, 16'h0, 16'h0);
      chk("same5_gap", 32'(rsp_ack), 32'h0);
      step(1'b0, 2'b10, 2'b00, 8'd0, 8'd5, 16'h0, 16'h0);
      chk("same5_ack1", 32'(rsp_ack), 32'h2);
      chk("same5_data1", 32'(rsp_rdata[31:16]), 32'h00A5);
      idle();
`endif

      // Continuous requests from both cores alternate grants 0,1,0,1...
      step(1'b0, 2'b10, 2'b00, 8'd0, 8'd7, 16'h0, 16'h0);
      idle();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 2'b11, 2'b00, 8'd3, 8'd7, 16'h0, 16'h0);
         if (i % 2 == 1) chk("alt_gap", 32'(rsp_ack), 32'h0);
         else chk("alt_grant", 32'(rsp_ack), ((i / 2) % 2 == 0) ? 32'h1 : 32'h2);
      end
      idle();

      // Out-of-range write must not alias onto 0x70; out-of-range read gives 0.
      step(1'b0, 2'b00, 2'b01, 8'h70, 8'd0, 16'h7070, 16'h0);
      idle();
      step(1'b0, 2'b00, 2'b10, 8'd0, 8'hF0, 16'h0, 16'hBEEF);
      chk("oor_wr_ack", 32'(rsp_ack), 32'h2);
      idle();
      step(1'b0, 2'b01, 2'b00, 8'h70, 8'd0, 16'h0, 16'h0);
      chk("oor_alias_data", 32'(rsp_rdata[15:0]), 32'h7070);
      idle();
      step(1'b0, 2'b10, 2'b00, 8'd0, 8'hF0, 16'h0, 16'h0);
      chk("oor_rd_ack", 32'(rsp_ack), 32'h2);
      chk("oor_rd_data", 32'(rsp_rdata[31:16]), 32'h0);
      idle();

      // Reset in the middle of a write's RESP cycle.
      step(1'b0, 2'b00, 2'b01, 8'd9, 8'd0, 16'h0999, 16'h0);
      chk("rstmid_ack_before", 32'(rsp_ack), 32'h1);
      reset = 1'b1;
      #1;
      chk("rstmid_ack", 32'(rsp_ack), 32'h0);
      chk("rstmid_busy", 32'(busy), 32'h0);
      chk("rstmid_rdata", 32'(rsp_rdata), 32'h0);
      step(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 16'h0, 16'h0);
      idle();
      step(1'b0, 2'b11, 2'b00, 8'd9, 8'd7, 16'h0, 16'h0);
      chk("post_rst_grant", 32'(rsp_ack), 32'h1);
      chk("post_rst_data", 32'(rsp_rdata[15:0]), 32'h0999);
      idle();

      // Randomized traffic: requests held until acked, occasional drops and resets.
      rd = '0;
      wr = '0;
      for (int c = 0; c < N; c++) begin
         pend[c] = 1'b0;
         ad[c]   = '0;
         wd[c]   = '0;
      end
      for (int t = 0; t < 3000; t++) begin
         bit rst;
         rst = ($urandom_range(0, 599) == 0);
         for (int c = 0; c < N; c++) begin
            if (m_ack[c] || !pend[c] || $urandom_range(0, 39) == 0) begin
               pend[c] = ($urandom_range(0, 2) != 0);
               if (pend[c]) begin
                  int kind;
                  kind  = $urandom_range(0, 9);
                  rd[c] = (kind < 5) || (kind == 9);
                  wr[c] = (kind >= 5);
                  ad[c] = ($urandom_range(0, 3) == 0) ? AL'($urandom_range(0, 255))
                                                      : AL'($urandom_range(0, 7));
                  wd[c] = DL'($urandom);
               end else begin
                  rd[c] = 1'b0;
                  wr[c] = 1'b0;
               end
            end
         end
         step(rst, rd, wr, ad[0], ad[1], wd[0], wd[1]);
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
